// File: rtl/fir_out_capture.sv
// Capture sink for the FIR output stream: skip a warm-up window, buffer a block, drain it.
// Optional running sum of the captured block is built when FIR_CAP_SUM_EN is defined.
module fir_out_capture #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 64,
    parameter int SKIP   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [DATA_W-1:0]                 i_y,
    input  logic                              i_y_valid,
    input  logic                              i_start,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic [DATA_W-1:0]                 o_peak,
    output logic [DATA_W-1:0]                 o_rd_data,
    output logic                              o_rd_valid,
    input  logic                              i_rd_ready,
    output logic [DATA_W+$clog2(DEPTH)-1:0]   o_sum
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SKW   = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SKW-1:0]    r_skipCnt;
    logic [AW-1:0]     r_wrPtr;
    logic [CW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_peak;
    logic              r_done;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_startAcc;
    logic              w_skipLast;
    logic              w_wrEn;
    logic              w_capLast;
    logic              w_rdFire;
    logic              w_rdLast;
    logic [DATA_W-1:0] w_abs;

    assign w_startAcc = (r_state == S_IDLE) && i_start;
    assign w_skipLast = (r_state == S_SKIP) && i_y_valid && (r_skipCnt == SKW'(SKIP - 1));
    assign w_wrEn     = (r_state == S_CAPTURE) && i_y_valid;
    assign w_capLast  = w_wrEn && (r_count == CW'(DEPTH - 1));
    assign w_rdFire   = o_rd_valid && i_rd_ready;
    assign w_rdLast   = w_rdFire && (r_rdPtr == CW'(DEPTH - 1));

    // Two's-complement magnitude kept at DATA_W bits: the most negative input maps to 2^(DATA_W-1)
    assign w_abs = i_y[DATA_W-1] ? (~i_y + DATA_W'(1)) : i_y;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (SKIP > 0) ? S_SKIP : S_CAPTURE;
                end
            end
            S_SKIP: begin
                if (w_skipLast) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_capLast) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_rdLast) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_skipCnt <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_peak    <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_startAcc) begin
                r_skipCnt <= '0;
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
                r_count   <= '0;
                r_peak    <= '0;
                r_done    <= 1'b0;
            end
            if ((r_state == S_SKIP) && i_y_valid) begin
                r_skipCnt <= r_skipCnt + SKW'(1);
            end
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + AW'(1);
                if (r_count != CW'(DEPTH)) begin
                    r_count <= r_count + CW'(1);
                end
                if (w_abs > r_peak) begin
                    r_peak <= w_abs;
                end
            end
            if (w_capLast) begin
                r_done <= 1'b1;
            end
            if (w_rdFire) begin
                r_rdPtr <= r_rdPtr + CW'(1);
            end
        end
    end

    // Buffer is deliberately left out of reset; writes are blocked during a reset cycle
    always_ff @(posedge i_clk) begin
        if (w_wrEn && !i_reset) begin
            r_mem[r_wrPtr] <= i_y;
        end
    end

`ifdef FIR_CAP_SUM_EN
    logic signed [DATA_W+AW-1:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_startAcc) begin
            r_sum <= '0;
        end else if (w_wrEn) begin
            r_sum <= r_sum + {{AW{i_y[DATA_W-1]}}, i_y};
        end
    end

    assign o_sum = r_sum;
`else
    assign o_sum = '0;
`endif

    assign o_busy     = (r_state == S_SKIP) || (r_state == S_CAPTURE);
    assign o_done     = r_done;
    assign o_count    = r_count;
    assign o_peak     = r_peak;
    assign o_rd_valid = (r_state == S_DRAIN) && (r_rdPtr != r_count);
    assign o_rd_data  = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: tb/tb_fir_out_capture.sv
// Self-checking bench for fir_out_capture: table-driven peak vectors plus scoreboarded capture/drain sequences.
module tb_fir_out_capture;

    localparam int DATA_W = 33;
    localparam int DEPTH  = 64;
    localparam int SKIP   = 16;
    localparam int CW     = 7;
    localparam int SUM_W  = 39;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] y;
    logic              yValid;
    logic              start;
    logic              rdReady;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] rdData;
    logic              rdValid;
    logic [SUM_W-1:0]  sum;

    int passCount  = 0;
    int checkCount = 0;

    logic [DATA_W-1:0]        expQ [$];
    logic [DATA_W-1:0]        modelPeak;
    logic signed [SUM_W-1:0]  modelSum;

    typedef struct {
        logic signed [DATA_W-1:0] special;
        logic [DATA_W-1:0]        expPeak;
        string                    name;
    } peakVec_t;

    peakVec_t vecs [5];

    always #5 clk = ~clk;

    fir_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP(SKIP)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_y        (y),
        .i_y_valid  (yValid),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_count    (count),
        .o_peak     (peak),
        .o_rd_data  (rdData),
        .o_rd_valid (rdValid),
        .i_rd_ready (rdReady),
        .o_sum      (sum)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] absVal(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W:0] w;
        w = v;
        if (w < 0) w = -w;
        return w[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] genSample(input int mode, input int vIdx,
                                                           input logic signed [DATA_W-1:0] special);
        int cIdx;
        cIdx = vIdx - SKIP;
        case (mode)
            2: begin
                if (vIdx < SKIP)    return DATA_W'(5000);
                else if (cIdx == 0) return -DATA_W'(5);
                else if (cIdx == 1) return DATA_W'(1000);
                else if (cIdx == 2) return special;
                else                return '0;
            end
            3:       return -DATA_W'(3);
            default: return DATA_W'(vIdx);
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] expectedSum();
`ifdef FIR_CAP_SUM_EN
        return modelSum;
`else
        return '0;
`endif
    endfunction

    // mode 0: y = index, continuous; 1: y_valid toggles; 2: peak block; 3: constant -3
    task automatic applyStimulus(input int mode, input logic signed [DATA_W-1:0] special);
        int vIdx     = 0;
        int captured = 0;
        int cycles   = 0;
        int total    = SKIP + DEPTH + 20;
        logic valid;
        logic signed [DATA_W-1:0] s;
        expQ.delete();
        modelPeak = '0;
        modelSum  = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("done_cleared_on_start", done, 0);
        checkOutput("count_cleared_on_start", count, 0);
        while (vIdx < total && cycles < 4 * total) begin
            valid = (mode != 1) || (cycles % 2 == 0);
            if (valid) begin
                s = genSample(mode, vIdx, special);
                y = s;
                yValid = 1'b1;
                if (vIdx >= SKIP && captured < DEPTH) begin
                    expQ.push_back(s);
                    if (absVal(s) > modelPeak) modelPeak = absVal(s);
                    modelSum = modelSum + SUM_W'(s);
                    captured++;
                    tick();
                    if (captured == DEPTH) begin
                        checkOutput("done_rise", done, 1);
                        checkOutput("busy_fall", busy, 0);
                        checkOutput("first_rd_valid", rdValid, 1);
                        checkOutput("first_rd_data", rdData, expQ[0]);
                    end else begin
                        checkOutput("count_progress", count, captured);
                        checkOutput("done_low_in_capture", done, 0);
                    end
                end else begin
                    tick();
                end
                vIdx++;
            end else begin
                y = 33'h1_2345_6789;
                yValid = 1'b0;
                tick();
                if (captured > 0 && captured < DEPTH) begin
                    checkOutput("count_hold_on_gap", count, captured);
                    checkOutput("busy_hold_on_gap", busy, 1);
                end
            end
            cycles++;
        end
        yValid = 1'b0;
        y = '0;
        checkOutput("stim_budget", vIdx, total);
        checkOutput("count_full", count, DEPTH);
        checkOutput("done_held", done, 1);
        checkOutput("peak_model", peak, modelPeak);
        checkOutput("sum_model", sum, expectedSum());
    endtask

    // mode 0: rd_ready always high; 1: rd_ready pattern 1,0,0,1 with start pulses during drain
    task automatic drainCheck(input int mode);
        int cycles = 0;
        int pat    = 0;
        logic rdy;
        logic pulsed;
        logic haveHeld = 1'b0;
        logic [DATA_W-1:0] held = '0;
        while (expQ.size() > 0 && cycles < 8 * DEPTH) begin
            checkOutput("rd_valid", rdValid, 1);
            checkOutput("rd_data", rdData, expQ[0]);
            if (haveHeld) checkOutput("rd_stable", rdData, held);
            rdy = (mode == 0) || (pat % 4 == 0) || (pat % 4 == 3);
            pulsed = (mode == 1) && (!rdy || expQ.size() == 1);
            start = pulsed;
            rdReady = rdy;
            tick();
            start = 1'b0;
            if (rdy) begin
                void'(expQ.pop_front());
                haveHeld = 1'b0;
            end else begin
                held = expQ[0];
                haveHeld = 1'b1;
            end
            if (pulsed) begin
                checkOutput("start_ignored_busy", busy, 0);
                checkOutput("start_ignored_done", done, 1);
            end
            cycles++;
            pat++;
        end
        rdReady = 1'b0;
        checkOutput("drain_budget", expQ.size(), 0);
        checkOutput("rd_valid_after_drain", rdValid, 0);
        checkOutput("busy_after_drain", busy, 0);
        checkOutput("done_after_drain", done, 1);
    endtask

    initial begin
        vecs[0] = '{special: 33'sh1_0000_0000, expPeak: 33'h1_0000_0000, name: "most_negative"};
        vecs[1] = '{special: 33'sh0_0000_0000, expPeak: 33'h0_0000_03E8, name: "without_min"};
        vecs[2] = '{special: -33'sd1001,       expPeak: 33'h0_0000_03E9, name: "neg_1001"};
        vecs[3] = '{special: 33'sh0_FFFF_FFFF, expPeak: 33'h0_FFFF_FFFF, name: "max_positive"};
        vecs[4] = '{special: -33'sd7,          expPeak: 33'h0_0000_03E8, name: "small_neg"};

        reset = 1'b1;
        start = 1'b0;
        yValid = 1'b0;
        y = '0;
        rdReady = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_peak", peak, 0);
        checkOutput("reset_rd_valid", rdValid, 0);
        checkOutput("reset_sum", sum, 0);
        reset = 1'b0;
        tick();

        $display("[TB] index stream, continuous valid");
        applyStimulus(0, '0);
        checkOutput("peak_index_stream", peak, 79);
        drainCheck(0);
        yValid = 1'b1;
        y = 33'h1_0000_0000;
        tick();
        tick();
        yValid = 1'b0;
        checkOutput("idle_valid_ignored_count", count, DEPTH);
        checkOutput("idle_valid_ignored_peak", peak, 79);
        checkOutput("idle_valid_ignored_busy", busy, 0);

        $display("[TB] peak magnitude table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, vecs[i].special);
            checkOutput({"peak_", vecs[i].name}, peak, vecs[i].expPeak);
            drainCheck(0);
        end

        $display("[TB] toggled y_valid and stalled drain");
        applyStimulus(1, '0);
        checkOutput("peak_toggled", peak, 79);
        drainCheck(1);

        $display("[TB] reset during capture");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < SKIP + 30; i++) begin
            y = DATA_W'(i);
            yValid = 1'b1;
            tick();
        end
        checkOutput("mid_capture_count", count, 30);
        checkOutput("mid_capture_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        yValid = 1'b0;
        checkOutput("abort_count", count, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_peak", peak, 0);
        checkOutput("abort_rd_valid", rdValid, 0);
        tick();
        applyStimulus(0, '0);
        drainCheck(0);

        $display("[TB] constant -3 block");
        applyStimulus(3, '0);
`ifdef FIR_CAP_SUM_EN
        checkOutput("sum_const_neg3", sum, SUM_W'(-192));
`else
        checkOutput("sum_const_neg3", sum, 0);
`endif
        checkOutput("peak_const_neg3", peak, 3);
        drainCheck(0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
